// File: rtl/fft_params_pkg.sv
// Shared FFT parameters, types and helpers.
//   N          : samples per frame (power of two)
//   STAGES     : log2(N); width of every address/counter field
//   DATA_W     : sample width, {16b real, 16b imag}
//   sample_t   : one complex sample, passed through untouched
//   addr_t     : in-frame sample index
//   bank_state_e : fill state of one ping-pong bank
//   bit_reverse: mirrors exactly STAGES index bits; the input bit-reversal
//                stage uses the same function, so both ends agree on ordering.
package fft_params_pkg;

  localparam int N      = 256;
  localparam int STAGES = 8;
  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] sample_t;
  typedef logic [STAGES-1:0] addr_t;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  function automatic addr_t bit_reverse(input addr_t a);
    addr_t r;
    for (int i = 0; i < STAGES; i++) begin
      r[i] = a[STAGES-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_output_reorder_if.sv
// Stream bundle for fft_output_reorder.
//   s_*        : bit-reversed input stream (valid/ready, s_last for checking)
//   m_*        : natural-order output stream (valid/ready, m_last on bin N-1)
//   frame_done : pulse after the m_last handshake
//   frame_err  : pulse when s_last disagrees with the sample count
// Modports: slave = reorder block, master = producer/consumer side.
interface fft_output_reorder_if #(
  parameter int DATA_W = 32
);

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              s_last;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              frame_done;
  logic              frame_err;

  modport slave (
    input  s_data, s_valid, s_last, m_ready,
    output s_ready, m_data, m_valid, m_last, frame_done, frame_err
  );

  modport master (
    output s_data, s_valid, s_last, m_ready,
    input  s_ready, m_data, m_valid, m_last, frame_done, frame_err
  );

endinterface

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample store for the output reorder buffer, kept separate so the
// array maps onto block RAM: one write port, one read port with an output
// register that only loads on re_i (so it holds under backpressure).
//   clk, rst  : clock; async active-high reset (output register only)
//   we_i, waddr_i, wdata_i : write port, address = {bank, index}
//   re_i, raddr_i          : read request, address = {bank, index}
//   rdata_o                : registered read data
module fft_pingpong_ram #(
  parameter int DATA_W = 32,
  parameter int STAGES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [STAGES:0]   waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [STAGES:0]   raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 << STAGES;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_output_reorder.sv
// Ping-pong reorder buffer at the FFT output. Samples arrive in bit-reversed
// order and are written to bitrev(count) of the write bank; a full bank is
// read out sequentially, giving natural order (bin 0..N-1). One bank fills
// while the other drains, so back-to-back frames stream at 1 sample/cycle.
//   clk, rst : clock; asynchronous active-high reset
//   bus      : fft_output_reorder_if.slave (s_* in, m_* out, frame pulses)
module fft_output_reorder #(
  parameter int DATA_W = 32,
  parameter int N      = fft_params_pkg::N,
  parameter int STAGES = fft_params_pkg::STAGES
) (
  input  logic                 clk,
  input  logic                 rst,
  fft_output_reorder_if.slave  bus
);

  import fft_params_pkg::*;

  typedef logic [STAGES-1:0] cnt_t;
  localparam cnt_t CNT_END = cnt_t'(N - 1);

  bank_state_e bank_q [2];
  bank_state_e bank_d [2];
  logic        wbank_q, wbank_d;
  logic        rbank_q, rbank_d;
  cnt_t        wcnt_q, wcnt_d;
  cnt_t        rcnt_q, rcnt_d;
  logic        m_valid_q, m_valid_d;
  logic        m_last_q, m_last_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_err_q, frame_err_d;

  logic        wr_en;
  logic        fetch;
  logic        wcnt_end;
  logic        rcnt_end;

  // s_ready comes purely from registers: no path from s_valid.
  assign bus.s_ready = (bank_q[wbank_q] == BANK_EMPTY);
  assign wr_en       = bus.s_valid && bus.s_ready;
  // Refill the output register when it is empty or being consumed now.
  assign fetch       = (bank_q[rbank_q] == BANK_FULL) && (!m_valid_q || bus.m_ready);
  assign wcnt_end    = (wcnt_q == CNT_END);
  assign rcnt_end    = (rcnt_q == CNT_END);

  always_comb begin
    bank_d       = bank_q;
    wbank_d      = wbank_q;
    rbank_d      = rbank_q;
    wcnt_d       = wcnt_q;
    rcnt_d       = rcnt_q;
    m_valid_d    = m_valid_q;
    m_last_d     = m_last_q;
    frame_done_d = m_valid_q && bus.m_ready && m_last_q;
    // Framing stays count-based; s_last only raises a flag.
    frame_err_d  = wr_en && (bus.s_last != wcnt_end);

    // Write and read always target different banks (EMPTY vs FULL), so the
    // two bank_d updates below never collide.
    if (wr_en) begin
      wcnt_d = wcnt_q + cnt_t'(1);
      if (wcnt_end) begin
        bank_d[wbank_q] = BANK_FULL;
        wbank_d         = ~wbank_q;
        wcnt_d          = '0;
      end
    end

    if (fetch) begin
      m_valid_d = 1'b1;
      m_last_d  = rcnt_end;
      rcnt_d    = rcnt_q + cnt_t'(1);
      if (rcnt_end) begin
        bank_d[rbank_q] = BANK_EMPTY;
        rbank_d         = ~rbank_q;
        rcnt_d          = '0;
      end
    end else if (bus.m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q[0]    <= BANK_EMPTY;
      bank_q[1]    <= BANK_EMPTY;
      wbank_q      <= 1'b0;
      rbank_q      <= 1'b0;
      wcnt_q       <= '0;
      rcnt_q       <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      bank_q       <= bank_d;
      wbank_q      <= wbank_d;
      rbank_q      <= rbank_d;
      wcnt_q       <= wcnt_d;
      rcnt_q       <= rcnt_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Read data register doubles as m_data: it loads only on fetch, so it
  // holds stable while m_valid && !m_ready.
  fft_pingpong_ram #(
    .DATA_W (DATA_W),
    .STAGES (STAGES)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_en),
    .waddr_i ({wbank_q, bit_reverse(addr_t'(wcnt_q))}),
    .wdata_i (bus.s_data),
    .re_i    (fetch),
    .raddr_i ({rbank_q, rcnt_q}),
    .rdata_o (bus.m_data)
  );

  assign bus.m_valid    = m_valid_q;
  assign bus.m_last     = m_last_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_fft_output_reorder.sv
module tb_fft_output_reorder;

  localparam int NN = fft_params_pkg::N;
  localparam int SW = fft_params_pkg::STAGES;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fft_output_reorder_if #(.DATA_W(32)) bus();

  fft_output_reorder #(
    .DATA_W (32),
    .N      (NN),
    .STAGES (SW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string name;
    int    nframes;
    int    pv;         // % chance of raising s_valid
    int    pr;         // % chance of m_ready
    int    mode;       // 0: data = bitrev(j) + frame<<16, 1: random
    int    err_idx;    // index in frame 0 where s_last is forced high, -1 none
    int    exp_errs;   // expected frame_err pulses
    bit    exp_no_stall;
  } vec_t;

  vec_t vecs[6];

  int checks = 0;
  int passes = 0;

  logic [31:0] src_d[$];
  bit          src_l[$];
  logic [31:0] exp_q[$];

  int acc_cnt, out_cnt, iter, err_cnt, stall_cnt, last_acc_iter, first_vld_iter;
  bit acc_now, done_exp, err_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Index reversal by plain arithmetic: peel low digits off j, push onto r.
  function automatic int ref_bitrev(input int j);
    int r = 0;
    int x = j;
    for (int i = 0; i < SW; i++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  // Reference model: sample j of a frame belongs to bin bitrev(j); the
  // expected stream is the bins listed 0..N-1.
  task automatic load_frames(input int nframes, input int mode, input int err_idx);
    logic [31:0] d;
    logic [31:0] nat [NN];
    for (int f = 0; f < nframes; f++) begin
      for (int j = 0; j < NN; j++) begin
        if (mode == 0) d = 32'(ref_bitrev(j) + (f << 16));
        else           d = $urandom;
        src_d.push_back(d);
        src_l.push_back((j == NN - 1) || (f == 0 && j == err_idx));
        nat[ref_bitrev(j)] = d;
      end
      for (int k = 0; k < NN; k++) exp_q.push_back(nat[k]);
    end
  endtask

  task automatic clear_stats();
    iter = 0; err_cnt = 0; stall_cnt = 0;
    last_acc_iter = -1; first_vld_iter = -1;
  endtask

  task automatic drive(input int pv, input int pr);
    @(posedge clk); #1;
    if (src_d.size() == 0) bus.s_valid = 1'b0;
    else if (!(bus.s_valid && !acc_now)) bus.s_valid = ($urandom_range(0, 99) < pv);
    if (src_d.size() != 0) begin
      bus.s_data = src_d[0];
      bus.s_last = src_l[0];
    end
    bus.m_ready = ($urandom_range(0, 99) < pr);
  endtask

  task automatic observe();
    @(negedge clk);
    chk("frame_done", 64'(bus.frame_done), 64'(done_exp));
    chk("frame_err", 64'(bus.frame_err), 64'(err_exp));
    if (bus.frame_err) err_cnt++;
    done_exp = bus.m_valid && bus.m_ready && bus.m_last;
    err_exp  = 1'b0;
    acc_now  = 1'b0;
    if (bus.s_valid && !bus.s_ready) stall_cnt++;
    if (bus.s_valid && bus.s_ready) begin
      err_exp = (bus.s_last != ((acc_cnt % NN) == NN - 1));
      acc_now = 1'b1;
      if ((acc_cnt % NN) == NN - 1 && last_acc_iter < 0) last_acc_iter = iter;
      acc_cnt++;
      void'(src_d.pop_front());
      void'(src_l.pop_front());
    end
    if (bus.m_valid && first_vld_iter < 0) first_vld_iter = iter;
    if (bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_output: got %0h expected no output", bus.m_data);
      end else begin
        chk("m_data", 64'(bus.m_data), 64'(exp_q.pop_front()));
        chk("m_last", 64'(bus.m_last), 64'((out_cnt % NN) == NN - 1));
      end
      out_cnt++;
    end
    iter++;
  endtask

  task automatic step(input int pv, input int pr);
    drive(pv, pr);
    observe();
  endtask

  task automatic drain(input string name, input int pv, input int pr, input int budget);
    while ((src_d.size() != 0 || exp_q.size() != 0) && iter < budget) step(pv, pr);
    if (iter >= budget) begin
      checks++;
      $display("FAIL %s_timeout: got %0d outputs pending, required 0", name, exp_q.size());
      src_d.delete(); src_l.delete(); exp_q.delete();
    end
    repeat (4) step(0, 100);
  endtask

  task automatic run_vec(input vec_t v);
    clear_stats();
    load_frames(v.nframes, v.mode, v.err_idx);
    drain(v.name, v.pv, v.pr, v.nframes * NN * 12 + 200);
    chk({v.name, "_latency"}, 64'(first_vld_iter - last_acc_iter), 64'(2));
    chk({v.name, "_errs"}, 64'(err_cnt), 64'(v.exp_errs));
    if (v.exp_no_stall) chk({v.name, "_stalls"}, 64'(stall_cnt), 64'(0));
  endtask

  initial begin
    int start_acc;
    int start_out;
    vecs[0] = '{"single",    1, 100, 100, 0,  -1, 0, 1'b1};
    vecs[1] = '{"b2b3",      3, 100, 100, 1,  -1, 0, 1'b1};
    vecs[2] = '{"rand50",    4,  50,  50, 1,  -1, 0, 1'b0};
    vecs[3] = '{"last_err",  1, 100, 100, 1, 100, 1, 1'b1};
    vecs[4] = '{"slow_sink", 2,  90,  25, 1,  -1, 0, 1'b0};
    vecs[5] = '{"post_rst",  1,  70,  80, 1,  -1, 0, 1'b0};

    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.m_ready = 1'b0;
    acc_cnt = 0; out_cnt = 0; acc_now = 0; done_exp = 0; err_exp = 0;
    clear_stats();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_s_ready", 64'(bus.s_ready), 64'(1));
    chk("rst_m_valid", 64'(bus.m_valid), 64'(0));
    chk("rst_m_data", 64'(bus.m_data), 64'(0));
    chk("rst_m_last", 64'(bus.m_last), 64'(0));
    chk("rst_frame_done", 64'(bus.frame_done), 64'(0));
    chk("rst_frame_err", 64'(bus.frame_err), 64'(0));

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Sink stalled: two frames absorbed, then s_ready must fall.
    clear_stats();
    load_frames(3, 1, -1);
    start_acc = acc_cnt;
    while (stall_cnt == 0 && iter < 700) step(100, 0);
    chk("bp_accepts", 64'(acc_cnt - start_acc), 64'(2 * NN));
    for (int i = 0; i < 5; i++) begin
      step(100, 0);
      chk("bp_hold_valid", 64'(bus.m_valid), 64'(1));
      chk("bp_hold_data", 64'(bus.m_data), 64'(exp_q[0]));
      chk("bp_hold_last", 64'(bus.m_last), 64'(0));
    end
    clear_stats();
    drain("bp_release", 100, 100, 3 * NN * 4);
    chk("bp_s_ready_back", 64'(bus.s_ready), 64'(1));

    // Reset while bin 50 is on the output, with a partial frame in the other bank.
    clear_stats();
    load_frames(1, 1, -1);
    for (int j = 0; j < 100; j++) begin
      src_d.push_back($urandom);
      src_l.push_back(1'b0);
    end
    start_out = out_cnt;
    while (out_cnt - start_out < 50 && iter < 2000) step(100, 100);
    chk("mid_rst_reached", 64'(out_cnt - start_out), 64'(50));
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_m_valid", 64'(bus.m_valid), 64'(0));
    chk("mid_rst_s_ready", 64'(bus.s_ready), 64'(1));
    bus.s_valid = 1'b0; bus.m_ready = 1'b0;
    src_d.delete(); src_l.delete(); exp_q.delete();
    acc_cnt = 0; out_cnt = 0; acc_now = 0; done_exp = 0; err_exp = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_stats();
    for (int i = 0; i < 20; i++) step(0, 100);
    chk("post_rst_idle", 64'(bus.m_valid), 64'(0));
    run_vec(vecs[5]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
